// File: rtl/riscv_if_prefetch_pkg.sv
// Shared types for the instruction prefetch buffer: the parcel FIFO entry and counter width.
package riscv_if_pkg;

    localparam int PFB_XLEN        = 32;
    localparam int PFB_PARCEL_SIZE = 32;
    localparam int PFB_DEPTH       = 4;
    localparam int PFB_CNT_W       = $clog2(PFB_DEPTH + 1);

    typedef struct packed {
        logic [PFB_XLEN-1:0]        pc;
        logic [PFB_PARCEL_SIZE-1:0] parcel;
        logic                       misaligned;
        logic                       page_fault;
    } pfb_entry_t;

endpackage

// File: rtl/riscv_if_prefetch_if.sv
// Core-fetch and instruction-memory signals of the prefetch buffer.
// slave = prefetch buffer view, master = core/memory view.
interface riscv_if_prefetch_if
    import riscv_if_pkg::*;
#(
    parameter int XLEN        = PFB_XLEN,
    parameter int PARCEL_SIZE = PFB_PARCEL_SIZE
);
    logic [XLEN-1:0]        if_nxt_pc;
    logic                   if_stall;
    logic                   if_flush;
    logic                   if_stall_nxt_pc;
    logic [PARCEL_SIZE-1:0] if_parcel;
    logic [XLEN-1:0]        if_parcel_pc;
    logic                   if_parcel_valid;
    logic                   if_parcel_misaligned;
    logic                   if_parcel_page_fault;

    logic                   imem_req;
    logic [XLEN-1:0]        imem_adr;
    logic                   imem_stall;
    logic                   imem_ack;
    logic [PARCEL_SIZE-1:0] imem_q;
    logic                   imem_err;
    logic                   imem_misaligned;
    logic                   imem_page_fault;

    modport slave (
        input  if_nxt_pc, if_stall, if_flush,
        output if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
               if_parcel_misaligned, if_parcel_page_fault,
        output imem_req, imem_adr,
        input  imem_stall, imem_ack, imem_q, imem_err, imem_misaligned, imem_page_fault
    );

    modport master (
        output if_nxt_pc, if_stall, if_flush,
        input  if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
               if_parcel_misaligned, if_parcel_page_fault,
        input  imem_req, imem_adr,
        output imem_stall, imem_ack, imem_q, imem_err, imem_misaligned, imem_page_fault
    );

endinterface

// File: rtl/riscv_if_prefetch_fifo.sv
// riscv_pfb_fifo: synchronous FIFO with combinational head, occupancy count and
// synchronous clear. DEPTH must be a power of two so the pointers wrap naturally.
module riscv_pfb_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [31:0],
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  entry_t           i_data,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_cnt,
    output entry_t           o_head
);

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // NOTE: storage has no reset; validity is carried by r_cnt alone.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_cnt  = r_cnt;
    assign o_head = r_mem[r_rd_ptr];

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(i_push && !i_pop && !i_clear && r_cnt == CNT_W'(DEPTH)));
            assert (!(i_pop && !i_clear && r_cnt == '0));
        end
    end

endmodule

// File: rtl/riscv_if_prefetch.sv
// Instruction prefetch buffer: pipelined imem requests, in-order parcel queue, stale-response drop.
// RISCV_IF_PREFETCH_BYPASS_EN: kept ack with an empty FIFO feeds if_parcel* in the same cycle.
module riscv_if_prefetch
    import riscv_if_pkg::*;
#(
    parameter int              XLEN        = PFB_XLEN,
    parameter logic [XLEN-1:0] PC_INIT     = 'h200,
    parameter int              PARCEL_SIZE = PFB_PARCEL_SIZE,
    parameter int              DEPTH       = PFB_DEPTH
) (
    input logic                clk,
    input logic                rst,
    riscv_if_prefetch_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_infl;
    logic [CNT_W-1:0] r_disc;
    logic [CNT_W-1:0] w_cnt_eff;
    logic [CNT_W:0]   w_sum;
    logic             w_space;
    logic             w_accept;
    logic             w_ack;
    logic             w_keep;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_valid;
    logic             w_valid;
    logic [XLEN-1:0]  w_pcq_head;
    logic [XLEN-1:0]  w_ack_pc;
    pfb_entry_t       w_new_entry;
    pfb_entry_t       w_head;
    pfb_entry_t       w_out;

    // Request side: a flush frees the whole FIFO this cycle, so the redirect can issue at once.
    assign w_cnt_eff = bus.if_flush ? '0 : w_cnt;
    assign w_sum     = (CNT_W+1)'(w_cnt_eff) + (CNT_W+1)'(w_infl);
    assign w_space   = w_sum < (CNT_W+1)'(DEPTH);

    assign bus.imem_req        = w_space;
    assign bus.imem_adr        = bus.if_nxt_pc;
    assign w_accept            = w_space & ~bus.imem_stall;
    assign bus.if_stall_nxt_pc = ~w_accept;

    // Response side: acks with nothing in flight are protocol errors and are ignored.
    assign w_ack    = bus.imem_ack & (w_infl != '0);
    assign w_keep   = w_ack & (r_disc == '0) & ~bus.if_flush;
    assign w_ack_pc = (w_infl != '0) ? w_pcq_head : PC_INIT;

    assign w_new_entry = '{
        pc:         w_ack_pc,
        parcel:     bus.imem_q,
        misaligned: bus.imem_misaligned,
        page_fault: bus.imem_page_fault | bus.imem_err
    };

    assign w_fifo_valid = w_cnt != '0;

`ifdef RISCV_IF_PREFETCH_BYPASS_EN
    assign w_bypass = w_keep & ~w_fifo_valid & ~bus.if_stall;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push  = w_keep & ~w_bypass;
    assign w_pop   = w_fifo_valid & ~bus.if_stall & ~bus.if_flush;
    assign w_valid = w_fifo_valid | w_bypass;
    assign w_out   = w_bypass ? w_new_entry : w_head;

    assign bus.if_parcel_valid      = w_valid;
    assign bus.if_parcel            = w_valid ? w_out.parcel     : '0;
    assign bus.if_parcel_pc         = w_valid ? w_out.pc         : '0;
    assign bus.if_parcel_misaligned = w_valid & w_out.misaligned;
    assign bus.if_parcel_page_fault = w_valid & w_out.page_fault;

    // Requests accepted in the flush cycle belong to the new path and are not counted as stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disc <= '0;
        end else if (bus.if_flush) begin
            r_disc <= w_infl - CNT_W'(w_ack);
        end else if (w_ack && r_disc != '0) begin
            r_disc <= r_disc - 1'b1;
        end
    end

    riscv_pfb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (logic [XLEN-1:0])
    ) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  (bus.if_nxt_pc),
        .i_pop   (w_ack),
        .i_clear (1'b0),
        .o_cnt   (w_infl),
        .o_head  (w_pcq_head)
    );

    riscv_pfb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (pfb_entry_t)
    ) u_parcel_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_new_entry),
        .i_pop   (w_pop),
        .i_clear (bus.if_flush),
        .o_cnt   (w_cnt),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_riscv_if_prefetch.sv
// Bench for riscv_if_prefetch: memory model plus parcel scoreboard, directed phases then random traffic.
module tb_riscv_if_prefetch;
    import riscv_if_pkg::*;

    localparam int DEPTH = 4;
`ifdef RISCV_IF_PREFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        int          due;
        bit          stale;
    } req_t;

    logic clk = 1'b0;
    logic rst;

    riscv_if_prefetch_if #(.XLEN(PFB_XLEN), .PARCEL_SIZE(PFB_PARCEL_SIZE)) bus ();

    riscv_if_prefetch #(
        .XLEN        (PFB_XLEN),
        .PC_INIT     (32'h200),
        .PARCEL_SIZE (PFB_PARCEL_SIZE),
        .DEPTH       (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    req_t        pend[$];
    pfb_entry_t  exp_q[$];
    pfb_entry_t  pop_log[$];
    int          n_pass = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    bit          ack_en = 1'b1;
    logic [31:0] next_pc = 32'h200;
    logic [31:0] err_pc = 32'h208;
    logic [31:0] mis_pc = 32'h210;
    logic [31:0] pf_pc  = 32'h214;
    int          first_acc_cyc = -1;
    int          first_valid_cyc = -1;
    logic        last_valid;
    logic        last_stall_nxt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] pc);
        return {pc[15:0] ^ 16'hc3a5, pc[31:16]} + 32'h1357_9bdf;
    endfunction

    function automatic pfb_entry_t make_entry(input logic [31:0] pc);
        pfb_entry_t e;
        e.pc         = pc;
        e.parcel     = mem_data(pc);
        e.misaligned = (pc == mis_pc);
        e.page_fault = (pc == pf_pc) || (pc == err_pc);
        return e;
    endfunction

    // Memory model: in-order acks once an accepted request has aged mem_lat cycles.
    task automatic drive();
        bus.if_nxt_pc = next_pc;
        if (ack_en && pend.size() != 0 && pend[0].due <= cyc) begin
            bus.imem_ack        = 1'b1;
            bus.imem_q          = mem_data(pend[0].pc);
            bus.imem_err        = (pend[0].pc == err_pc);
            bus.imem_misaligned = (pend[0].pc == mis_pc);
            bus.imem_page_fault = (pend[0].pc == pf_pc);
        end else begin
            bus.imem_ack        = 1'b0;
            bus.imem_q          = $urandom();
            bus.imem_err        = 1'b0;
            bus.imem_misaligned = 1'b0;
            bus.imem_page_fault = 1'b0;
        end
    endtask

    task automatic finish_cycle();
        int         sz;
        bit         exp_req, acc, kept, exp_valid;
        pfb_entry_t e;
        @(negedge clk);
        sz      = exp_q.size();
        exp_req = ((bus.if_flush ? 0 : sz) + pend.size()) < DEPTH;
        check("imem_req", bus.imem_req, exp_req);
        acc = exp_req && !bus.imem_stall;
        check("stall_nxt_pc", bus.if_stall_nxt_pc, !acc);
        check("imem_adr", bus.imem_adr, next_pc);
        kept = 1'b0;
        if (bus.imem_ack) begin
            e    = make_entry(pend[0].pc);
            kept = !pend[0].stale && !bus.if_flush;
            void'(pend.pop_front());
            if (kept) exp_q.push_back(e);
        end
        exp_valid = (sz != 0) || (BYPASS && kept && !bus.if_stall);
        check("parcel_valid", bus.if_parcel_valid, exp_valid);
        if (bus.if_parcel_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        last_valid     = bus.if_parcel_valid;
        last_stall_nxt = bus.if_stall_nxt_pc;
        if (exp_valid) begin
            e = exp_q[0];
            check("parcel_pc", bus.if_parcel_pc, e.pc);
            check("parcel", bus.if_parcel, e.parcel);
            check("flags", {bus.if_parcel_misaligned, bus.if_parcel_page_fault},
                  {e.misaligned, e.page_fault});
            if (!bus.if_stall && !bus.if_flush) begin
                pop_log.push_back(e);
                void'(exp_q.pop_front());
            end
        end else begin
            check("empty_outputs", {bus.if_parcel, bus.if_parcel_pc,
                  bus.if_parcel_misaligned, bus.if_parcel_page_fault}, '0);
        end
        if (bus.if_flush) begin
            exp_q.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
        end
        if (acc) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            pend.push_back('{pc: next_pc, due: cyc + mem_lat, stale: 1'b0});
            next_pc = next_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        drive();
        finish_cycle();
    endtask

    task automatic drain();
        int k;
        bus.if_stall   = 1'b0;
        bus.if_flush   = 1'b0;
        bus.imem_stall = 1'b1;
        ack_en         = 1'b1;
        k = 0;
        while (k < 60 && (pend.size() != 0 || exp_q.size() != 0)) begin
            step();
            k++;
        end
        check("drain_done", (pend.size() == 0 && exp_q.size() == 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, pf_pops;
        bit found;

        rst                 = 1'b1;
        bus.if_nxt_pc       = next_pc;
        bus.if_stall        = 1'b0;
        bus.if_flush        = 1'b0;
        bus.imem_stall      = 1'b0;
        bus.imem_ack        = 1'b0;
        bus.imem_q          = '0;
        bus.imem_err        = 1'b0;
        bus.imem_misaligned = 1'b0;
        bus.imem_page_fault = 1'b0;
        #2;
        check("rst_imem_req", bus.imem_req, 1);
        check("rst_stall_nxt_pc", bus.if_stall_nxt_pc, 0);
        check("rst_valid", bus.if_parcel_valid, 0);
        check("rst_outputs", {bus.if_parcel, bus.if_parcel_pc,
              bus.if_parcel_misaligned, bus.if_parcel_page_fault}, '0);
        check("rst_imem_adr", bus.imem_adr, 32'h200);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming at latency 1
        mem_lat = 1;
        repeat (14) step();
        check("first_latency", first_valid_cyc - first_acc_cyc, BYPASS ? 1 : 2);
        check("stream_pops_ge12", pop_log.size() >= 12, 1);
        pf_pops = 0;
        foreach (pop_log[i]) if (pop_log[i].page_fault) pf_pops++;
        check("stream_page_fault_count", pf_pops, 2);

        // Backpressure: core stalls, queue fills, then releases
        bus.if_stall = 1'b1;
        repeat (10) step();
        check("bp_stall_nxt_pc", last_stall_nxt, 1);
        bus.if_stall = 1'b0;
        repeat (6) step();
        drain();

        // Flush with two requests in flight
        ack_en         = 1'b0;
        bus.imem_stall = 1'b0;
        repeat (2) step();
        bus.imem_stall = 1'b1;
        step();
        next_pc        = 32'h400;
        bus.if_flush   = 1'b1;
        bus.imem_stall = 1'b0;
        step();
        bus.if_flush   = 1'b0;
        bus.imem_stall = 1'b1;
        step();
        check("flush2_valid_next", last_valid, 0);
        mark = pop_log.size();
        drain();
        check("flush2_pops", pop_log.size() - mark, 1);
        if (pop_log.size() > mark) check("flush2_first_pc", pop_log[mark].pc, 32'h400);
        else check("flush2_first_pc", 0, 32'h400);

        // Flush coinciding with an ack and a head pop
        mem_lat        = 2;
        bus.imem_stall = 1'b0;
        found          = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            drive();
            if (bus.imem_ack && exp_q.size() != 0 && pend.size() >= 2) begin
                found         = 1'b1;
                next_pc       = 32'h800;
                bus.if_nxt_pc = next_pc;
                bus.if_flush  = 1'b1;
            end
            finish_cycle();
        end
        check("flush_ack_found", found, 1);
        bus.if_flush   = 1'b0;
        bus.imem_stall = 1'b1;
        step();
        check("flush_ack_valid_next", last_valid, 0);
        mark = pop_log.size();
        drain();
        if (pop_log.size() > mark) check("flush_ack_first_pc", pop_log[mark].pc, 32'h800);
        else check("flush_ack_first_pc", 0, 32'h800);

        // Random traffic
        next_pc = 32'h1000;
        for (int k = 0; k < 300; k++) begin
            bus.if_stall   = ($urandom_range(0, 3) == 0);
            bus.imem_stall = ($urandom_range(0, 4) == 0);
            ack_en         = ($urandom_range(0, 3) != 0);
            mem_lat        = $urandom_range(1, 3);
            bus.if_flush   = ($urandom_range(0, 24) == 0);
            if (bus.if_flush) next_pc = {20'h0, 4'h2, $urandom_range(0, 255) & 8'hfc};
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
